// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard/stall controller: FSM encoding,
// default parameters and the register-zero constant.
package hazard_ctrl_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    MISS = 1'b1
  } ctrl_state_t;

  localparam int          MISS_TIMEOUT_DEF = 1023;
  localparam int          CNT_W_DEF        = 32;
  localparam int          WD_W             = 10;
  localparam logic [4:0]  REG_ZERO         = 5'd0;

endpackage

// File: rtl/hazard_stall_ctrl_miss_watchdog.sv
// Miss-duration watchdog: saturating cycle counter with a sticky timeout flag.
// The flag is visible in the same cycle the count reaches LIMIT.
module miss_watchdog
  import hazard_ctrl_pkg::*;
#(
  parameter int LIMIT = MISS_TIMEOUT_DEF
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic en_i,
  output logic flag_o
);

  localparam logic [WD_W-1:0] LIM    = WD_W'(LIMIT);
  localparam logic [WD_W-1:0] LIM_M1 = WD_W'(LIMIT - 1);

  logic [WD_W-1:0] cnt;
  logic            sticky;
  logic            hit;

  // en_i marks the current miss cycle; this one completes LIMIT cycles when cnt == LIMIT-1
  assign hit    = en_i & (cnt == LIM_M1);
  assign flag_o = sticky | hit;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt    <= '0;
      sticky <= 1'b0;
    end else begin
      if (clear_i)
        cnt <= '0;
      else if (en_i && cnt != LIM)
        cnt <= cnt + 1'b1;
      if (hit)
        sticky <= 1'b1;
    end
  end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline advance/stall/bubble/flush controller with data-cache miss FSM.
// Optional performance counters are built when HAZARD_CTRL_PERF_CNT_EN is defined.
module hazard_stall_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MISS_TIMEOUT = MISS_TIMEOUT_DEF,
  parameter int CNT_W        = CNT_W_DEF
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [4:0] id_rs_i,
  input  logic [4:0] id_rt_i,
  input  logic [4:0] ex_rt_i,
  input  logic       ex_memread_i,
  input  logic       branch_taken_i,
  input  logic       dcache_stall_i,
  output logic       pc_write_o,
  output logic       ifid_write_o,
  output logic       ifid_flush_o,
  output logic       idex_bubble_o,
  output logic       back_freeze_o,
  output logic       miss_state_o,
  output logic       timeout_o
`ifdef HAZARD_CTRL_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] loaduse_cnt_o,
  output logic [CNT_W-1:0] miss_cnt_o
`endif
);

  ctrl_state_t state;
  logic        hazard;

  assign hazard = ex_memread_i & (ex_rt_i != REG_ZERO)
                & ((ex_rt_i == id_rs_i) | (ex_rt_i == id_rt_i));

  // Priority stall > hazard > branch; everything held low while in reset
  always_comb begin
    pc_write_o    = 1'b0;
    ifid_write_o  = 1'b0;
    ifid_flush_o  = 1'b0;
    idex_bubble_o = 1'b0;
    back_freeze_o = 1'b0;
    if (!rst_i) begin
      if (dcache_stall_i) begin
        back_freeze_o = 1'b1;
      end else if (hazard) begin
        idex_bubble_o = 1'b1;
      end else begin
        pc_write_o   = 1'b1;
        ifid_write_o = 1'b1;
        ifid_flush_o = branch_taken_i;
      end
    end
  end

  assign miss_state_o = (state == MISS);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      state <= RUN;
    else
      state <= dcache_stall_i ? MISS : RUN;
  end

  miss_watchdog #(
    .LIMIT (MISS_TIMEOUT)
  ) u_watchdog (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear_i ((state == RUN) & dcache_stall_i),
    .en_i    (state == MISS),
    .flag_o  (timeout_o)
  );

`ifdef HAZARD_CTRL_PERF_CNT_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      loaduse_cnt_o <= '0;
      miss_cnt_o    <= '0;
    end else begin
      if (idex_bubble_o)
        loaduse_cnt_o <= loaduse_cnt_o + CNT_W'(1);
      if (back_freeze_o)
        miss_cnt_o <= miss_cnt_o + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl with a short watchdog limit (4).
// Counter checks compile in when HAZARD_CTRL_PERF_CNT_EN is defined.
module tb_hazard_stall_ctrl;
  localparam int TO = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs, id_rt, ex_rt;
  logic       ex_memread, branch_taken, dcache_stall;
  logic       pc_write, ifid_write, ifid_flush, idex_bubble, back_freeze;
  logic       miss_state, timeout;
  logic [5:0] ctl;
  int         n_cmp = 0;
  int         n_err = 0;
`ifdef HAZARD_CTRL_PERF_CNT_EN
  logic [31:0] loaduse_cnt, miss_cnt;
`endif

  always #5 clk = ~clk;

  hazard_stall_ctrl #(.MISS_TIMEOUT(TO), .CNT_W(32)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .id_rs_i        (id_rs),
    .id_rt_i        (id_rt),
    .ex_rt_i        (ex_rt),
    .ex_memread_i   (ex_memread),
    .branch_taken_i (branch_taken),
    .dcache_stall_i (dcache_stall),
    .pc_write_o     (pc_write),
    .ifid_write_o   (ifid_write),
    .ifid_flush_o   (ifid_flush),
    .idex_bubble_o  (idex_bubble),
    .back_freeze_o  (back_freeze),
    .miss_state_o   (miss_state),
    .timeout_o      (timeout)
`ifdef HAZARD_CTRL_PERF_CNT_EN
    ,
    .loaduse_cnt_o  (loaduse_cnt),
    .miss_cnt_o     (miss_cnt)
`endif
  );

  // {pc_write, ifid_write, ifid_flush, idex_bubble, back_freeze, miss_state}
  assign ctl = {pc_write, ifid_write, ifid_flush, idex_bubble, back_freeze, miss_state};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic mr, input logic [4:0] ert, input logic [4:0] rs,
                     input logic [4:0] rt, input logic br, input logic st);
    ex_memread   = mr;
    ex_rt        = ert;
    id_rs        = rs;
    id_rt        = rt;
    branch_taken = br;
    dcache_stall = st;
    #1;
  endtask

  initial begin
    rst = 1'b1;
    drv(1, 5, 5, 0, 1, 1);
    chk("rst_ctl", 32'(ctl), 32'b000000);
    chk("rst_timeout", 32'(timeout), 0);
`ifdef HAZARD_CTRL_PERF_CNT_EN
    chk("rst_loaduse_cnt", loaduse_cnt, 0);
    chk("rst_miss_cnt", miss_cnt, 0);
`endif
    cyc();
    rst = 1'b0;
    drv(0, 0, 0, 0, 0, 0);
    chk("idle", 32'(ctl), 32'b110000);

    cyc(); drv(1, 5, 5, 0, 0, 0);
    chk("loaduse_rs", 32'(ctl), 32'b000100);
    cyc(); drv(0, 0, 0, 0, 0, 0);
    chk("after_loaduse", 32'(ctl), 32'b110000);
`ifdef HAZARD_CTRL_PERF_CNT_EN
    chk("loaduse_cnt_1", loaduse_cnt, 1);
`endif
    cyc(); drv(1, 7, 3, 7, 0, 0);
    chk("loaduse_rt", 32'(ctl), 32'b000100);
    cyc(); drv(0, 7, 3, 7, 0, 0);
    chk("no_load", 32'(ctl), 32'b110000);
    cyc(); drv(1, 0, 0, 0, 0, 0);
    chk("zero_reg", 32'(ctl), 32'b110000);
    cyc(); drv(0, 0, 0, 0, 1, 0);
    chk("branch", 32'(ctl), 32'b111000);
    cyc(); drv(1, 9, 9, 9, 1, 0);
    chk("haz_over_branch", 32'(ctl), 32'b000100);
    cyc(); drv(0, 0, 0, 0, 0, 0);
`ifdef HAZARD_CTRL_PERF_CNT_EN
    chk("loaduse_cnt_3", loaduse_cnt, 3);
`endif

    for (int i = 1; i <= 8; i++) begin
      cyc(); drv(0, 0, 0, 0, 0, 1);
      chk("miss_ctl", 32'(ctl), (i > 1) ? 32'b000011 : 32'b000010);
      chk("miss_timeout", 32'(timeout), (i >= 5) ? 1 : 0);
    end
    cyc(); drv(0, 0, 0, 0, 0, 0);
    chk("miss_exit", 32'(ctl), 32'b110001);
`ifdef HAZARD_CTRL_PERF_CNT_EN
    chk("miss_cnt_8", miss_cnt, 8);
`endif
    cyc();
    chk("run_after_miss", 32'(ctl), 32'b110000);
    chk("timeout_sticky", 32'(timeout), 1);

    rst = 1'b1; #1;
    chk("timeout_rst", 32'(timeout), 0);
    cyc();
    rst = 1'b0;
    drv(0, 0, 0, 0, 0, 0);
`ifdef HAZARD_CTRL_PERF_CNT_EN
    chk("cnt_rst", loaduse_cnt | miss_cnt, 0);
`endif

    cyc(); drv(1, 4, 4, 0, 1, 1);
    chk("stall_priority", 32'(ctl), 32'b000010);
    cyc(); drv(1, 4, 4, 0, 1, 0);
    chk("haz_after_stall", 32'(ctl), 32'b000101);
    cyc(); drv(0, 0, 0, 0, 0, 0);
    chk("clear_after_haz", 32'(ctl), 32'b110000);

    cyc(); drv(0, 0, 0, 0, 0, 1);
    chk("pulse_freeze", 32'(ctl), 32'b000010);
    cyc(); drv(0, 0, 0, 0, 0, 0);
    chk("pulse_miss", 32'(ctl), 32'b110001);
    cyc();
    chk("pulse_run", 32'(ctl), 32'b110000);
    chk("timeout_short_miss", 32'(timeout), 0);

    for (int i = 1; i <= 10; i++) begin
      cyc(); drv(0, 0, 0, 0, 0, 1);
      chk("wd_timeout", 32'(timeout), (i >= 5) ? 1 : 0);
    end
    cyc(); drv(0, 0, 0, 0, 0, 0);
    chk("wd_exit", 32'(ctl), 32'b110001);
    chk("wd_hold", 32'(timeout), 1);

    for (int i = 1; i <= 3; i++) begin
      cyc(); drv(0, 0, 0, 0, 0, 1);
    end
    chk("midmiss_state", 32'(miss_state), 1);
    rst = 1'b1; #1;
    chk("midmiss_rst_ctl", 32'(ctl), 32'b000000);
    chk("midmiss_rst_timeout", 32'(timeout), 0);
    cyc();
    rst = 1'b0;
    drv(0, 0, 0, 0, 0, 0);
    chk("post_rst_run", 32'(ctl), 32'b110000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
